decode_issue_ctrl: RTL and testbench



---
 rtl/decode_issue_ctrl.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_decode_issue_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_issue_ctrl.sv
// -----------------------------------------------------------------------------
// decode_issue_ctrl
//
// Decode/issue sequencer between fetch and the execute stage. Fetched
// instructions are accepted over a valid/ready handshake into a small circular
// FIFO. The instruction at the FIFO head is mirrored into a registered issue
// slot together with its decoded immediate-select code and register fields.
// That FIFO entry is retired only when execute accepts the issue slot. A
// one-cycle bubble is inserted when the instruction behind an accepted LOAD
// reads the LOAD's destination register.
//
// Optional feature (macro ILLEGAL_TRAP_EN):
//   When defined, unrecognised opcodes issue with illegal=1 and imm_sel=000.
//   Once such an instruction is accepted, the controller parks in TRAP until
//   flush. When undefined, illegal is tied to 0 and unknown opcodes issue
//   normally with imm_sel=000.
//
// Parameters:
//   DEPTH  buffer entries (power of two, >= 2)
//   PC_W   program-counter width
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   flush      synchronous; empties the buffer and drops the issue slot
//   in_valid   fetch presents an instruction
//   in_ready   buffer can accept (not full)
//   in_instr   instruction word
//   in_pc      instruction address
//   out_valid  issue slot valid
//   out_ready  execute accepts the issue slot
//   out_instr  issued instruction (feeds the immediate generator)
//   out_pc     issued PC
//   imm_sel    immediate-select code of the issued instruction
//   rs1/rs2/rd register fields of the issued instruction
//   is_load    issued instruction is a LOAD
//   illegal    issued instruction is illegal (0 unless ILLEGAL_TRAP_EN)
// -----------------------------------------------------------------------------
module decode_issue_ctrl #(
  parameter int DEPTH = 2,
  parameter int PC_W  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [PC_W-1:0] out_pc,
  output logic [2:0]      imm_sel,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic            is_load,
  output logic            illegal
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

`ifdef ILLEGAL_TRAP_EN
  typedef enum logic [1:0] {ST_ISSUE = 2'd0, ST_BUBBLE = 2'd1, ST_TRAP = 2'd2} state_t;
`else
  typedef enum logic [0:0] {ST_ISSUE = 1'b0, ST_BUBBLE = 1'b1} state_t;
`endif

  // Contents of the issue slot.
  typedef struct packed {
    logic [31:0]     instr;
    logic [PC_W-1:0] pc;
    logic [2:0]      imm_sel;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            is_load;
  } issue_t;

  // ---------------------------------------------------------------------------
  // Decode helpers
  // ---------------------------------------------------------------------------
  function automatic logic [2:0] imm_sel_of(input logic [31:0] i);
    logic [2:0] sel;
    case (i[6:0])
      OPC_OP_IMM:          sel = (i[14:12] == 3'b001 || i[14:12] == 3'b101) ? 3'b100 : 3'b001;
      OPC_LOAD, OPC_JALR:  sel = 3'b001;
      OPC_STORE:           sel = 3'b010;
      OPC_LUI, OPC_AUIPC:  sel = 3'b011;
      default:             sel = 3'b000;
    endcase
    return sel;
  endfunction

  function automatic logic reads_rs1(input logic [31:0] i);
    return !(i[6:0] == OPC_LUI || i[6:0] == OPC_AUIPC || i[6:0] == OPC_JAL);
  endfunction

  function automatic logic reads_rs2(input logic [31:0] i);
    return (i[6:0] == OPC_OP || i[6:0] == OPC_STORE || i[6:0] == OPC_BRANCH);
  endfunction

`ifdef ILLEGAL_TRAP_EN
  function automatic logic illegal_of(input logic [31:0] i);
    logic known;
    case (i[6:0])
      OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH,
      OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC: known = 1'b1;
      default:                               known = 1'b0;
    endcase
    return !known || (i[1:0] != 2'b11);
  endfunction
`endif

  // ---------------------------------------------------------------------------
  // FIFO storage and pointers
  // ---------------------------------------------------------------------------
  logic [31:0]     mem_instr [DEPTH];
  logic [PC_W-1:0] mem_pc    [DEPTH];
  logic [AW:0]     wr_ptr, rd_ptr;
  logic [AW:0]     count, cnt_after, rd_ptr_after;
  logic            full;
  logic            push, pop;

  state_t          state;
  issue_t          out_q;

  assign count = wr_ptr - rd_ptr;
  // The extra pointer MSB differs only when the writer has lapped the reader.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign in_ready = !full;
  assign push     = in_valid && in_ready && !flush;
  // The issue slot mirrors the FIFO head; the entry retires on acceptance.
  assign pop      = out_valid && out_ready && !flush;

  // ---------------------------------------------------------------------------
  // Next issue candidate: the head left after this cycle's pop, or the
  // incoming word when the buffer would otherwise be empty (1-cycle latency).
  // ---------------------------------------------------------------------------
  logic        head_avail;
  logic [31:0] cand_instr;
  issue_t      cand;
  logic        slot_free;
  logic        load_hazard;
  logic        trap_enter;

  assign rd_ptr_after = rd_ptr + {{AW{1'b0}}, pop};
  assign cnt_after    = count - {{AW{1'b0}}, pop};
  assign head_avail   = (cnt_after != '0) || push;
  assign slot_free    = !out_valid || out_ready;

  always_comb begin
    cand = '0;
    if (cnt_after != '0) begin
      cand_instr = mem_instr[rd_ptr_after[AW-1:0]];
      cand.pc    = mem_pc[rd_ptr_after[AW-1:0]];
    end else begin
      cand_instr = in_instr;
      cand.pc    = in_pc;
    end
    cand.instr   = cand_instr;
    cand.imm_sel = imm_sel_of(cand_instr);
    cand.rs1     = cand_instr[19:15];
    cand.rs2     = cand_instr[24:20];
    cand.rd      = cand_instr[11:7];
    cand.is_load = (cand_instr[6:0] == OPC_LOAD);
`ifdef ILLEGAL_TRAP_EN
    if (illegal_of(cand_instr)) cand.imm_sel = 3'b000;
`endif
  end

  // Hazard is judged against the accepted LOAD still held in the slot.
  assign load_hazard = out_valid && out_ready && out_q.is_load && (out_q.rd != 5'd0) &&
                       head_avail &&
                       ((reads_rs1(cand_instr) && cand.rs1 == out_q.rd) ||
                        (reads_rs2(cand_instr) && cand.rs2 == out_q.rd));

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q;
  assign trap_enter = out_valid && out_ready && illegal_q;
  assign illegal    = illegal_q;
`else
  assign trap_enter = 1'b0;
  assign illegal    = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Storage write port
  // ---------------------------------------------------------------------------
  // NOTE: the data array carries no reset; occupancy lives in the pointers, so
  // stale words are never observed and the array maps onto plain RAM cells.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr[wr_ptr[AW-1:0]] <= in_instr;
      mem_pc[wr_ptr[AW-1:0]]    <= in_pc;
    end
  end

  // ---------------------------------------------------------------------------
  // Pointers, FSM and issue slot
  // ---------------------------------------------------------------------------
  // NOTE: all state here uses non-blocking assignments so every read in this
  // block sees the pre-edge value, matching the combinational logic above.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      state     <= ST_ISSUE;
      out_valid <= 1'b0;
      out_q     <= '0;
`ifdef ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      state     <= ST_ISSUE;
      out_valid <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      case (state)
        ST_ISSUE: begin
          if (trap_enter) begin
`ifdef ILLEGAL_TRAP_EN
            state     <= ST_TRAP;
`endif
            out_valid <= 1'b0;
          end else if (load_hazard) begin
            state     <= ST_BUBBLE;
            out_valid <= 1'b0;
          end else if (slot_free) begin
            out_valid <= head_avail;
            if (head_avail) begin
              out_q <= cand;
`ifdef ILLEGAL_TRAP_EN
              illegal_q <= illegal_of(cand_instr);
`endif
            end
          end
        end
        ST_BUBBLE: begin
          // Slot is empty during the bubble, so the held head issues now.
          state     <= ST_ISSUE;
          out_valid <= head_avail;
          if (head_avail) begin
            out_q <= cand;
`ifdef ILLEGAL_TRAP_EN
            illegal_q <= illegal_of(cand_instr);
`endif
          end
        end
`ifdef ILLEGAL_TRAP_EN
        ST_TRAP: begin
          out_valid <= 1'b0;
        end
`endif
        default: begin
          state     <= ST_ISSUE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_instr = out_q.instr;
  assign out_pc    = out_q.pc;
  assign imm_sel   = out_q.imm_sel;
  assign rs1       = out_q.rs1;
  assign rs2       = out_q.rs2;
  assign rd        = out_q.rd;
  assign is_load   = out_q.is_load;

endmodule

// File: tb/tb_decode_issue_ctrl.sv
module tb_decode_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [2:0]  imm_sel;
  logic [4:0]  rs1, rs2, rd;
  logic        is_load;
  logic        illegal;

  int checks = 0;
  int errors = 0;

  decode_issue_ctrl #(.DEPTH(2), .PC_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_pc    (out_pc),
    .imm_sel   (imm_sel),
    .rs1       (rs1),
    .rs2       (rs2),
    .rd        (rd),
    .is_load   (is_load),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        ld;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled there.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
    in_valid = v;
    in_instr = instr;
    in_pc    = pc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    //              instr         imm     rs1    rs2    rd     ld
    vecs[0]  = '{32'h00500093, 3'b001, 5'd0,  5'd5,  5'd1,  1'b0}; // addi x1,x0,5
    vecs[1]  = '{32'h0020A223, 3'b010, 5'd1,  5'd2,  5'd4,  1'b0}; // sw x2,4(x1)
    vecs[2]  = '{32'h00309093, 3'b100, 5'd1,  5'd3,  5'd1,  1'b0}; // slli x1,x1,3
    vecs[3]  = '{32'h123450B7, 3'b011, 5'd8,  5'd3,  5'd1,  1'b0}; // lui x1
    vecs[4]  = '{32'h0000A283, 3'b001, 5'd1,  5'd0,  5'd5,  1'b1}; // lw x5,0(x1)
    vecs[5]  = '{32'h00228333, 3'b000, 5'd5,  5'd2,  5'd6,  1'b0}; // add x6,x5,x2
    vecs[6]  = '{32'h00000517, 3'b011, 5'd0,  5'd0,  5'd10, 1'b0}; // auipc x10
    vecs[7]  = '{32'h000080E7, 3'b001, 5'd1,  5'd0,  5'd1,  1'b0}; // jalr x1,0(x1)
    vecs[8]  = '{32'h4020D093, 3'b100, 5'd1,  5'd2,  5'd1,  1'b0}; // srai x1,x1,2
    vecs[9]  = '{32'h00208463, 3'b000, 5'd1,  5'd2,  5'd8,  1'b0}; // beq x1,x2,8
    vecs[10] = '{32'h008000EF, 3'b000, 5'd0,  5'd8,  5'd1,  1'b0}; // jal x1,8

    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    step(); step();

    // Reset state
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready",  in_ready, 1);
    check("rst_out_instr", out_instr, 0);
    check("rst_out_pc",    out_pc, 0);
    check("rst_fields",    {imm_sel, rs1, rs2, rd, is_load, illegal}, 0);
    rst = 1'b0;
    out_ready = 1'b1;
    step();

    // Decode table: each instruction issues the cycle after it is pushed,
    // then drains on the following cycle.
    for (int i = 0; i < NV; i++) begin
      drive(1'b1, vecs[i].instr, 32'h1000 + 32'(i) * 4);
      step();
      check($sformatf("v%0d_valid", i),   out_valid, 1);
      check($sformatf("v%0d_instr", i),   out_instr, vecs[i].instr);
      check($sformatf("v%0d_pc", i),      out_pc, 32'h1000 + 32'(i) * 4);
      check($sformatf("v%0d_imm_sel", i), imm_sel, vecs[i].imm);
      check($sformatf("v%0d_rs1", i),     rs1, vecs[i].rs1);
      check($sformatf("v%0d_rs2", i),     rs2, vecs[i].rs2);
      check($sformatf("v%0d_rd", i),      rd, vecs[i].rd);
      check($sformatf("v%0d_is_load", i), is_load, vecs[i].ld);
      check($sformatf("v%0d_illegal", i), illegal, 0);
      drive(1'b0, 32'h0, 32'h0);
      step();
      check($sformatf("v%0d_drained", i), out_valid, 0);
    end

    // Back-to-back stream: one issue per cycle, in order.
    drive(1'b1, 32'h0020A223, 32'h2000); step();
    check("b2b_sw", {out_valid, out_instr, imm_sel}, {1'b1, 32'h0020A223, 3'b010});
    drive(1'b1, 32'h00309093, 32'h2004); step();
    check("b2b_slli", {out_valid, out_instr, imm_sel}, {1'b1, 32'h00309093, 3'b100});
    drive(1'b1, 32'h123450B7, 32'h2008); step();
    check("b2b_lui", {out_valid, out_instr, imm_sel}, {1'b1, 32'h123450B7, 3'b011});
    drive(1'b0, 32'h0, 32'h0); step();
    check("b2b_end", out_valid, 0);

    // Backpressure: buffer fills after two pushes, slot stays stable.
    out_ready = 1'b0;
    drive(1'b1, 32'h00500093, 32'h3000); step();
    check("bp_first_issued", {out_valid, out_instr}, {1'b1, 32'h00500093});
    check("bp_ready_after1", in_ready, 1);
    drive(1'b1, 32'h0020A223, 32'h3004); step();
    check("bp_ready_after2", in_ready, 0);
    check("bp_stable1", {out_valid, out_instr, out_pc}, {1'b1, 32'h00500093, 32'h3000});
    drive(1'b1, 32'h00309093, 32'h3008); step();
    check("bp_ready_after3", in_ready, 0);
    check("bp_stable2", {out_valid, out_instr, out_pc, imm_sel}, {1'b1, 32'h00500093, 32'h3000, 3'b001});
    drive(1'b0, 32'h0, 32'h0);
    out_ready = 1'b1;
    step();
    check("bp_drain2", {out_valid, out_instr, out_pc}, {1'b1, 32'h0020A223, 32'h3004});
    check("bp_ready_back", in_ready, 1);
    step();
    check("bp_drained", out_valid, 0);
    check("bp_ready_empty", in_ready, 1);

    // Load-use: lw x5 then add reading x5 -> single bubble cycle.
    drive(1'b1, 32'h0000A283, 32'h4000); step();
    check("lu_lw", {out_valid, out_instr, is_load}, {1'b1, 32'h0000A283, 1'b1});
    drive(1'b1, 32'h00228333, 32'h4004); step();
    check("lu_bubble", out_valid, 0);
    drive(1'b0, 32'h0, 32'h0); step();
    check("lu_add", {out_valid, out_instr, out_pc}, {1'b1, 32'h00228333, 32'h4004});
    step();
    check("lu_end", out_valid, 0);

    // lw x0 followed by a reader of x0: no bubble.
    drive(1'b1, 32'h0000A003, 32'h4100); step();
    check("lu0_lw", {out_valid, out_instr}, {1'b1, 32'h0000A003});
    drive(1'b1, 32'h00200333, 32'h4104); step();
    check("lu0_no_bubble", {out_valid, out_instr}, {1'b1, 32'h00200333});
    drive(1'b0, 32'h0, 32'h0); step();
    check("lu0_end", out_valid, 0);

    // lw x5 followed by an independent addi: no bubble.
    drive(1'b1, 32'h0000A283, 32'h4200); step();
    drive(1'b1, 32'h00500093, 32'h4204); step();
    check("luind_no_bubble", {out_valid, out_instr}, {1'b1, 32'h00500093});
    drive(1'b0, 32'h0, 32'h0); step();

    // Flush while full and stalled, with a competing push.
    out_ready = 1'b0;
    drive(1'b1, 32'h00309093, 32'h5000); step();
    drive(1'b1, 32'h123450B7, 32'h5004); step();
    check("fl_full", in_ready, 0);
    flush = 1'b1;
    drive(1'b1, 32'h00000517, 32'h5008); step();
    check("fl_out_valid", out_valid, 0);
    check("fl_in_ready", in_ready, 1);
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    out_ready = 1'b1;
    step(); step();
    check("fl_nothing_left", out_valid, 0);
    drive(1'b1, 32'h0020A223, 32'h5010); step();
    check("fl_recover", {out_valid, out_instr, out_pc}, {1'b1, 32'h0020A223, 32'h5010});
    drive(1'b0, 32'h0, 32'h0); step();

    // Reset in the middle of operation drops buffered entries at once.
    out_ready = 1'b0;
    drive(1'b1, 32'h00309093, 32'h6000); step();
    drive(1'b1, 32'h123450B7, 32'h6004); step();
    drive(1'b0, 32'h0, 32'h0);
    #2 rst = 1'b1;
    #1;
    check("mrst_out_valid", out_valid, 0);
    check("mrst_in_ready",  in_ready, 1);
    check("mrst_out_instr", out_instr, 0);
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    step(); step();
    check("mrst_empty", out_valid, 0);

    // Illegal instruction followed by addi.
    drive(1'b1, 32'hFFFFFFFF, 32'h7000); step();
    check("ill_issue", {out_valid, out_instr, imm_sel}, {1'b1, 32'hFFFFFFFF, 3'b000});
`ifdef ILLEGAL_TRAP_EN
    check("ill_flag", illegal, 1);
    drive(1'b1, 32'h00500093, 32'h7004); step();
    check("trap_hold1", out_valid, 0);
    drive(1'b0, 32'h0, 32'h0); step();
    check("trap_hold2", out_valid, 0);
    step();
    check("trap_hold3", out_valid, 0);
    check("trap_in_ready", in_ready, 1);
    flush = 1'b1; step();
    flush = 1'b0;
    check("trap_flush", out_valid, 0);
    step();
    check("trap_addi_gone", out_valid, 0);
    drive(1'b1, 32'h00500093, 32'h7010); step();
    check("trap_recover", {out_valid, out_instr, illegal}, {1'b1, 32'h00500093, 1'b0});
`else
    check("ill_flag", illegal, 0);
    drive(1'b1, 32'h00500093, 32'h7004); step();
    check("ill_next", {out_valid, out_instr, imm_sel, illegal}, {1'b1, 32'h00500093, 3'b001, 1'b0});
`endif
    drive(1'b0, 32'h0, 32'h0); step();
    check("final_idle", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
